// File: rtl/grant_decoder.sv
// Registered 3-to-8 grant decoder with valid/ready acceptance, HOLD-cycle grant window and GAP idle spacing.
// Drives a one-hot or thermometer grant vector from an accepted priority-encoder index.
module grant_decoder #(
  parameter  int unsigned IN_W  = 3,
  parameter  int unsigned HOLD  = 4,
  parameter  int unsigned GAP   = 1,
  localparam int unsigned OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_mode,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept;

  // Bit i set when i equals the code (one-hot) or does not exceed it (thermometer).
  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code, input logic mode);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      v[i] = mode ? (IN_W'(i) <= code) : (IN_W'(i) == code);
    end
    return v;
  endfunction

  assign in_ready = en && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and counter; dropping en aborts to IDLE from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_ACTIVE;
            cnt_d   = CNT_W'(HOLD - 1);
          end
        end
        ST_ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP - 1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs follow the next state; the code is captured only on accept
  always_comb begin
    out_d       = '0;
    out_valid_d = (state_d == ST_ACTIVE);
    busy_d      = (state_d != ST_IDLE);
    if (accept) begin
      out_d = decode(in_code, in_mode);
    end else if (state_d == ST_ACTIVE) begin
      out_d = out_q;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
